// File: rtl/mix_run_ctrl.sv
// mix_run_ctrl -- MIX instruction-cycle sequencer.
//   Steps FETCH -> DECODE -> EXEC -> WAIT -> DONE for each instruction and
//   launches the command units. It stops at an instruction boundary on HLT,
//   on a stop request or in step mode. It restarts on the GO button, which is
//   a cold start at PC 0, or on the continue button, which resumes at the
//   current PC. It owns the HLT-flag clear and counts completed instructions.
//
// Optional feature macro: WATCHDOG_EN. When it is defined, a WAIT that lasts
//   WDOG_CYCLES cycles without cmd_done raises a sticky fault and halts.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   go, cont        front-panel button levels; rising edges act in HALTED only
//   stop            stop request pulse, honoured at the next boundary
//   step_mode       halt after every completed instruction
//   hlt             sticky HLT flag, sampled in DONE only
//   mem_ready       fetched instruction word valid
//   cmd_done        completion pulse from the active command unit
//   mem_req         fetch request (held through FETCH)
//   ir_load, exec_start, pc_clr, pc_next, hlt_clr   single-cycle strobes
//   running/halted  sequencer status
//   fault           sticky watchdog fault
//   instr_count     completed instructions since the last GO (wraps)
module mix_run_ctrl #(
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             cont,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             hlt,
  input  logic             mem_ready,
  input  logic             cmd_done,
  output logic             mem_req,
  output logic             ir_load,
  output logic             exec_start,
  output logic             pc_clr,
  output logic             pc_next,
  output logic             hlt_clr,
  output logic             running,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALTED, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_DONE
  } state_t;

  state_t           r_state, w_nxt;
  logic             r_go_q, r_cont_q;
  logic             r_stop_pend;
  logic             r_pc_clr, r_hlt_clr;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;
  logic             w_go_rise, w_cont_rise, w_start, w_halt_req, w_wd_expire;

  assign w_go_rise   = go & ~r_go_q;
  assign w_cont_rise = cont & ~r_cont_q;
  assign w_start     = (r_state == S_HALTED) & (w_go_rise | w_cont_rise);
  // stop arriving in the DONE cycle itself still stops at this boundary.
  assign w_halt_req  = hlt | r_stop_pend | stop | step_mode | r_fault;

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  // r_wdog equals the number of WAIT cycles already spent before this one;
  // cmd_done on the expiring cycle still completes normally.
  assign w_wd_expire = (r_state == S_WAIT) & ~cmd_done &
                       (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_wdog <= '0;
    else if (r_state == S_EXEC)  r_wdog <= '0;
    else if (r_state == S_WAIT)  r_wdog <= r_wdog + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)           r_fault <= 1'b0;
    else if (w_start)     r_fault <= 1'b0;
    else if (w_wd_expire) r_fault <= 1'b1;
  end
`else
  assign w_wd_expire = 1'b0;
  assign r_fault     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_HALTED;
    else        r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_HALTED: if (w_go_rise | w_cont_rise) w_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) w_nxt = S_DECODE;
      S_DECODE: w_nxt = S_EXEC;
      S_EXEC:   w_nxt = S_WAIT;
      S_WAIT: begin
        if (cmd_done)         w_nxt = S_DONE;
        else if (w_wd_expire) w_nxt = S_HALTED;
      end
      S_DONE:   w_nxt = w_halt_req ? S_HALTED : S_FETCH;
      default:  w_nxt = S_HALTED;
    endcase
  end

  // Button edges, stop latch, restart strobes and the instruction counter.
  // The edge registers load during reset so a button held through reset
  // does not look like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_go_q      <= go;
      r_cont_q    <= cont;
      r_stop_pend <= 1'b0;
      r_pc_clr    <= 1'b0;
      r_hlt_clr   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_go_q    <= go;
      r_cont_q  <= cont;
      r_pc_clr  <= 1'b0;
      r_hlt_clr <= 1'b0;
      if (w_start) begin
        r_hlt_clr   <= 1'b1;
        r_stop_pend <= 1'b0;
        if (w_go_rise) begin
          r_pc_clr <= 1'b1;
          r_count  <= '0;
        end
      end else if (r_state == S_DONE) begin
        r_count     <= r_count + 1'b1;
        r_stop_pend <= 1'b0;
      end else if (r_state != S_HALTED && stop) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  // Moore output decode
  always_comb begin
    mem_req     = (r_state == S_FETCH);
    ir_load     = (r_state == S_DECODE);
    exec_start  = (r_state == S_EXEC);
    pc_next     = (r_state == S_DONE);
    pc_clr      = r_pc_clr;
    hlt_clr     = r_hlt_clr;
    running     = (r_state != S_HALTED);
    halted      = (r_state == S_HALTED);
    fault       = r_fault;
    instr_count = r_count;
  end

endmodule

// File: doc/mix_run_ctrl.md
Name: mix_run_ctrl

Overview:
Instruction-cycle sequencer for the MIX core. It runs fetch/decode/execute/complete and launches each command unit. It stops at an instruction boundary on HLT, on a stop button or in step mode, and restarts on the GO and continue front-panel buttons. It owns clearing of the sticky HLT flag and keeps a completed-instruction counter.

Parameters:
CNT_W, 32, width of instr_count (wraps modulo 2^CNT_W)
WDOG_CYCLES, 4095, max cycles in WAIT before fault (used only with WATCHDOG_EN)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
go  in  1  GO button level (debounced upstream); rising edge = cold start at address 0
cont  in  1  continue button level; rising edge = resume at current PC
stop  in  1  stop request pulse; honoured at next instruction boundary
step_mode  in  1  level; halt after every completed instruction
hlt  in  1  sticky HLT flag from the HLT command unit
mem_ready  in  1  instruction word valid from memory
cmd_done  in  1  one-cycle completion pulse from the active command unit
mem_req  out  1  instruction fetch request
ir_load  out  1  one-cycle load strobe for instruction register
exec_start  out  1  one-cycle start pulse to decoded command unit
pc_clr  out  1  one-cycle clear of PC to 0 (GO only)
pc_next  out  1  one-cycle PC advance/commit at instruction completion
hlt_clr  out  1  one-cycle clear of the HLT flag
running  out  1  high in all states except HALTED
halted  out  1  high in HALTED
fault  out  1  sticky watchdog fault (0 without WATCHDOG_EN)
instr_count  out  CNT_W  completed instructions since last GO

Behaviour:
- Reset (rst_n=0 at posedge): state HALTED, halted=1, all other outputs 0, instr_count=0, stop_pend=0, button edge registers loaded with the current go/cont levels (no spurious edge after reset). Reset mid-instruction aborts immediately, with no pc_next.
- Edge detect: go_rise = go & ~go_q; cont_rise = cont & ~cont_q. Both registered every cycle.
- Outputs are Moore-decoded from registered state/flags. All strobes are exactly 1 cycle.
- HALTED
  - go_rise: next state FETCH; pc_clr=1 and hlt_clr=1 for that transition cycle; instr_count<=0; fault<=0; stop_pend<=0.
  - cont_rise (no go_rise): FETCH; hlt_clr=1; fault<=0; stop_pend<=0.
  - go has priority when both edges occur together. Edges seen outside HALTED are ignored.
- FETCH: mem_req=1 held. On mem_ready=1, go to DECODE. Otherwise stay.
- DECODE: ir_load=1. Next state EXEC.
- EXEC: exec_start=1. Next state WAIT.
- WAIT: waits for cmd_done; cmd_done outside WAIT is ignored. On cmd_done, go to DONE.
- DONE: pc_next=1; instr_count+1 (wraps). Next state:
  - HALTED if hlt | stop_pend | step_mode | fault_set, with stop_pend cleared;
  - otherwise FETCH.
- Minimum instruction time is 5 cycles with mem_ready and cmd_done immediate.
- stop: sets stop_pend in any non-HALTED state. stop in HALTED is ignored. stop in the DONE cycle is honoured at that same boundary.
- hlt is sampled only in DONE. The HLT instruction itself completes, with pc_next issued, before halting.

Optional Feature:
WATCHDOG_EN
- Defined: counter clears on entry to WAIT and increments each WAIT cycle. If it reaches WDOG_CYCLES without cmd_done, then fault<=1 and state goes HALTED directly, with no pc_next and no instr_count increment. fault stays high until go_rise or cont_rise. cmd_done on the expiry cycle wins: normal completion, no fault.
- Undefined: no counter; fault tied 0; WAIT waits indefinitely.

Test Plan:
- Reset, then go 0->1 -> pc_clr and hlt_clr pulse once. Then mem_req, ir_load, exec_start in successive cycles. With mem_ready and cmd_done immediate: pc_next 5 cycles after start, instr_count=1.
- 3 instructions, then hlt=1 with cmd_done on the 4th -> pc_next pulses, instr_count=4, halted=1, mem_req stays 0. cont rise -> hlt_clr, resumes with instr_count continuing at 4.
- step_mode=1, cont pulsed 3 times -> exactly one instruction per press, instr_count=3. go held high throughout -> no extra start.
- stop pulse during WAIT with cmd_done 10 cycles later -> instruction completes (pc_next, count+1), then HALTED. stop while halted -> no effect.
- rst_n=0 during WAIT -> next cycle halted=1, no pc_next, instr_count=0. go and cont rising together in HALTED -> pc_clr=1 (go wins).
- WATCHDOG_EN, WDOG_CYCLES=8, cmd_done withheld -> fault=1 and halted after 8 WAIT cycles, no pc_next. Repeat with cmd_done on cycle 8 -> no fault.
